// File: rtl/lr_shift_arbiter.sv
// ============================================================================
// Module  : lr_shift_arbiter
// Brief   : Round-robin sharing of one external left/right shifter between two
//           valid/ready requesters, with registered operands and result.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module lr_shift_arbiter #(
  parameter int WIDTH = 8,
  localparam int SW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_bits,
  input  logic [SW-1:0]    req0_shift,
  input  logic             req0_dir,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_bits,
  input  logic [SW-1:0]    req1_shift,
  input  logic             req1_dir,
  output logic [WIDTH-1:0] sh_iBits,
  output logic [SW-1:0]    sh_shift,
  output logic             sh_dir,
  input  logic [WIDTH-1:0] sh_oBits,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_bits,
  output logic             resp_id
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t           state_q;
  logic             rr_last_q;
  logic [WIDTH-1:0] op_bits_q;
  logic [SW-1:0]    op_shift_q;
  logic             op_dir_q;
  logic             op_id_q;
  logic [WIDTH-1:0] resp_bits_q;
  logic             resp_id_q;
  logic             resp_valid_q;

  logic             grant0;
  logic             grant1;
  logic [WIDTH-1:0] op_bits_d;
  logic [SW-1:0]    op_shift_d;
  logic             op_dir_d;

  // Contention goes to the requester that did not win last; readies only in IDLE.
  always_comb begin
    grant0     = (state_q == S_IDLE) && req0_valid && (!req1_valid || rr_last_q);
    grant1     = (state_q == S_IDLE) && req1_valid && (!req0_valid || !rr_last_q);
    op_bits_d  = grant1 ? req1_bits  : req0_bits;
    op_shift_d = grant1 ? req1_shift : req0_shift;
    op_dir_d   = grant1 ? req1_dir   : req0_dir;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rr_last_q    <= 1'b1;
      op_bits_q    <= '0;
      op_shift_q   <= '0;
      op_dir_q     <= 1'b0;
      op_id_q      <= 1'b0;
      resp_bits_q  <= '0;
      resp_id_q    <= 1'b0;
      resp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (grant0 || grant1) begin
            op_bits_q  <= op_bits_d;
            op_shift_q <= op_shift_d;
            op_dir_q   <= op_dir_d;
            op_id_q    <= grant1;
            rr_last_q  <= grant1;
            state_q    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          resp_bits_q  <= sh_oBits;
          resp_id_q    <= op_id_q;
          resp_valid_q <= 1'b1;
          state_q      <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        default: begin
          resp_valid_q <= 1'b0;
          state_q      <= S_IDLE;
        end
      endcase
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign sh_iBits   = op_bits_q;
  assign sh_shift   = op_shift_q;
  assign sh_dir     = op_dir_q;
  assign resp_valid = resp_valid_q;
  assign resp_bits  = resp_bits_q;
  assign resp_id    = resp_id_q;

endmodule

`default_nettype wire
